// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction memory
// and holds the CPU core in reset until a frame completes with a matching checksum.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  byte_q, byte_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] to_q, to_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        in_frame;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    word_d    = word_q;
    chk_d     = chk_q;
    to_d      = to_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    in_frame  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                (state_q == S_DATA)   || (state_q == S_CHECK);

    if (in_frame) begin
      to_d = rx_valid ? 32'd0 : to_q + 32'd1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d   = S_LEN_LO;
          len_d     = 16'd0;
          idx_d     = 16'd0;
          byte_d    = 2'd0;
          word_d    = 32'd0;
          chk_d     = 8'd0;
          to_d      = 32'd0;
          addr_d    = BASE_ADDR;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_d   = {len_q[15:8], rx_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_d = {rx_data, len_q[7:0]};
          if (32'(len_d) > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            done_d  = 1'b0;
          end else if (len_d == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          word_d[{byte_q, 3'b000} +: 8] = rx_data;
          chk_d  = chk_q + rx_data;
          byte_d = byte_q + 2'd1;
          // A word is only committed once its fourth byte arrives
          if (byte_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
            data_d = word_d;
            idx_d  = idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            err_d     = 1'b0;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte silence inside a frame aborts it
    if (in_frame && !rx_valid && to_d >= TIMEOUT_CYCLES) begin
      state_d   = S_ERROR;
      err_d     = 1'b1;
      done_d    = 1'b0;
      cpu_rst_d = 1'b1;
      to_d      = 32'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      idx_q     <= 16'd0;
      byte_q    <= 2'd0;
      word_q    <= 32'd0;
      chk_q     <= 8'd0;
      to_q      <= 32'd0;
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      data_q    <= 32'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      word_q    <= word_d;
      chk_q     <= chk_d;
      to_q      <= to_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_data = data_q;
  assign cpu_reset = cpu_rst_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed frames plus randomized frames checked against
// a frame-level model of the expected writes and final status.
module tb_program_loader;

  localparam int unsigned TO   = 40;
  localparam int unsigned MAXW = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef logic [7:0] bq_t[$];

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_reset;
  logic        done;
  logic        error;

  int nchecks = 0;
  int nerrors = 0;
  logic [63:0] wr_q[$];

  program_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error)
  );

  always #5 clock = ~clock;

  // Record every memory write shortly after the edge that produced it
  always @(posedge clock) begin
    #1;
    if (imem_we === 1'b1) wr_q.push_back({imem_addr, imem_data});
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic bq_t make_frame(input int len, input bit good);
    bq_t f;
    logic [7:0] s;
    logic [7:0] b;
    logic [15:0] l16;
    s = 8'h00;
    l16 = 16'(len);
    f.push_back(8'hA5);
    f.push_back(l16[7:0]);
    f.push_back(l16[15:8]);
    for (int i = 0; i < 4 * len; i++) begin
      b = 8'($urandom);
      s = s + b;
      f.push_back(b);
    end
    f.push_back(good ? s : s + 8'd1 + 8'($urandom_range(0, 254)));
    return f;
  endfunction

  // Drives one frame and checks each byte's effect plus the final status
  task automatic send_frame(input bq_t f, input int gap_max);
    int len, k, n0, exp_words;
    bit exp_we, exp_good;
    logic [7:0] s;
    logic [31:0] w, ea;
    len = int'({f[2], f[1]});
    exp_good = 1'b0;
    exp_words = 0;
    if (len <= int'(MAXW)) begin
      s = 8'h00;
      for (int i = 0; i < 4 * len; i++) s = s + f[3 + i];
      exp_good = (s == f[3 + 4 * len]);
      exp_words = len;
    end
    n0 = wr_q.size();
    for (int p = 0; p < f.size(); p++) begin
      send_byte(f[p]);
      exp_we = 1'b0;
      w = 32'd0;
      ea = 32'd0;
      if (len <= int'(MAXW) && p >= 3 && p < 3 + 4 * len && ((p - 3) % 4) == 3) begin
        exp_we = 1'b1;
        k = (p - 3) / 4;
        w = {f[p], f[p - 1], f[p - 2], f[p - 3]};
        ea = BASE + 32'(4 * k);
      end
      nchecks++;
      if (imem_we !== exp_we) begin
        nerrors++;
        $display("FAIL frame_we byte %0d: got %b expected %b", p, imem_we, exp_we);
      end
      if (exp_we) begin
        nchecks++;
        if (imem_addr !== ea || imem_data !== w) begin
          nerrors++;
          $display("FAIL frame_write byte %0d: got %h@%h expected %h@%h", p, imem_data, imem_addr, w, ea);
        end
      end
      if (p < f.size() - 1) begin
        nchecks++;
        if (cpu_reset !== 1'b1) begin
          nerrors++;
          $display("FAIL frame_cpu_reset byte %0d: got %b expected 1", p, cpu_reset);
        end
        if (gap_max > 0) idle($urandom_range(0, gap_max));
      end
    end
    nchecks++;
    if (done !== exp_good || error !== !exp_good || cpu_reset !== !exp_good) begin
      nerrors++;
      $display("FAIL frame_status: got done=%b error=%b cpu_reset=%b expected done=%b error=%b cpu_reset=%b",
               done, error, cpu_reset, exp_good, !exp_good, !exp_good);
    end
    nchecks++;
    if (wr_q.size() - n0 != exp_words) begin
      nerrors++;
      $display("FAIL frame_write_count: got %0d expected %0d", wr_q.size() - n0, exp_words);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    nchecks++;
    if (imem_we !== 1'b0 || imem_addr !== BASE || imem_data !== 32'd0 ||
        cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_values: got we=%b addr=%h data=%h cpu_reset=%b done=%b error=%b expected 0,%h,0,1,0,0",
               imem_we, imem_addr, imem_data, cpu_reset, done, error, BASE);
    end
  endtask

  task automatic test_directed();
    bq_t f;
    int n0;
    n0 = wr_q.size();
    f = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame(f, 0);
    nchecks++;
    if (wr_q.size() != n0 + 1 || wr_q[wr_q.size() - 1] !== {32'h0, 32'h0000_0013}) begin
      nerrors++;
      $display("FAIL single_word: got %0d writes last=%h expected 1 write 00000000_00000013",
               wr_q.size() - n0, wr_q[wr_q.size() - 1]);
    end
    nchecks++;
    if (done !== 1'b1 || cpu_reset !== 1'b0) begin
      nerrors++;
      $display("FAIL single_word_done: got done=%b cpu_reset=%b expected 1,0", done, cpu_reset);
    end
    for (int c = 0; c < 2; c++) begin
      n0 = wr_q.size();
      f = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
      if (c == 1) f[11] = 8'h25;
      send_frame(f, 2);
      nchecks++;
      if (wr_q.size() != n0 + 2 || wr_q[n0] !== {32'h0, 32'h0403_0201} ||
          wr_q[n0 + 1] !== {32'h4, 32'h0807_0605}) begin
        nerrors++;
        $display("FAIL two_words chk%0d: got %0d writes expected 04030201@0 08070605@4", c, wr_q.size() - n0);
      end
      nchecks++;
      if (done !== (c == 0) || error !== (c == 1) || cpu_reset !== (c == 1)) begin
        nerrors++;
        $display("FAIL two_words_status chk%0d: got done=%b error=%b cpu_reset=%b", c, done, error, cpu_reset);
      end
    end
  endtask

  task automatic test_length_bounds();
    bq_t f;
    f = '{8'hA5, 8'h01, 8'h04};
    send_frame(f, 0);
    nchecks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      nerrors++;
      $display("FAIL over_length: got error=%b done=%b expected 1,0", error, done);
    end
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(f, 0);
    f = make_frame(int'(MAXW), 1'b1);
    send_frame(f, 0);
  endtask

  task automatic test_timeout();
    int n0;
    n0 = wr_q.size();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    idle(int'(TO) - 1);
    nchecks++;
    if (error !== 1'b0 || cpu_reset !== 1'b1) begin
      nerrors++;
      $display("FAIL timeout_early: got error=%b cpu_reset=%b expected 0,1", error, cpu_reset);
    end
    idle(1);
    nchecks++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || wr_q.size() != n0) begin
      nerrors++;
      $display("FAIL timeout: got error=%b done=%b cpu_reset=%b writes=%0d expected 1,0,1,0",
               error, done, cpu_reset, wr_q.size() - n0);
    end
    send_frame(make_frame(1, 1'b1), 0);
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    n0 = wr_q.size();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    nchecks++;
    if (imem_we !== 1'b0 || imem_addr !== BASE || imem_data !== 32'd0 ||
        cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_mid_values: got we=%b addr=%h data=%h cpu_reset=%b done=%b error=%b",
               imem_we, imem_addr, imem_data, cpu_reset, done, error);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    idle(2);
    nchecks++;
    if (wr_q.size() != n0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
      nerrors++;
      $display("FAIL reset_mid_nowrite: got writes=%0d cpu_reset=%b done=%b expected 0,1,0",
               wr_q.size() - n0, cpu_reset, done);
    end
  endtask

  task automatic test_random();
    bit good;
    bit last_good;
    logic [7:0] junk;
    last_good = 1'b0;
    for (int n = 0; n < 12; n++) begin
      good = 1'($urandom);
      send_frame(make_frame($urandom_range(0, 5), good), 3);
      last_good = good;
      for (int j = 0; j < 3; j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      nchecks++;
      if (done !== last_good || error !== !last_good || cpu_reset !== !last_good) begin
        nerrors++;
        $display("FAIL random_junk %0d: got done=%b error=%b expected done=%b", n, done, error, last_good);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      send_frame(make_frame($urandom_range(1, 4), 1'(n != 2)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_length_bounds();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
